// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op encodings, FSM states and sign helpers shared by the
// HI/LO multiply/divide unit and its divide datapath.
package muldiv_pkg;

    localparam int MAXW = 64;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MADD  = 3'b100;
    localparam logic [2:0] OP_MADDU = 3'b101;
    localparam logic [2:0] OP_MSUB  = 3'b110;
    localparam logic [2:0] OP_MSUBU = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        FIX
    } state_t;

    // Conditional two's-complement negate; callers zero-extend a narrower
    // value in and keep only their low bits, which stay exact modulo 2^W.
    function automatic logic [MAXW-1:0] neg_if(
        input logic [MAXW-1:0] v,
        input logic            neg
    );
        return neg ? (~v + MAXW'(1)) : v;
    endfunction

    function automatic logic op_is_div(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic op_signed(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_DIV) ||
               (op == OP_MADD) || (op == OP_MSUB);
    endfunction

    function automatic logic op_is_sub(input logic [2:0] op);
        return (op == OP_MSUB) || (op == OP_MSUBU);
    endfunction

    function automatic logic op_is_acc(input logic [2:0] op);
        return (op == OP_MADD) || (op == OP_MADDU) || op_is_sub(op);
    endfunction

endpackage

// File: rtl/muldiv_hilo_div_iter.sv
// div_iter: restoring radix-2 divider on unsigned magnitudes.
// One quotient bit per step; quotient/remainder show the post-step value.
module div_iter
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             last
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvs_q;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   shifted;
    logic             ge;

    // Dividend bits are consumed MSB-first while quotient bits fill from the LSB.
    assign shifted   = {rem_q, quo_q[WIDTH-1]};
    assign ge        = shifted >= {1'b0, dvs_q};
    assign remainder = WIDTH'(ge ? shifted - {1'b0, dvs_q} : shifted);
    assign quotient  = {quo_q[WIDTH-2:0], ge};
    assign last      = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            cnt   <= '0;
        end else if (load) begin
            rem_q <= '0;
            quo_q <= dividend;
            dvs_q <= divisor;
            cnt   <= '0;
        end else if (step) begin
            rem_q <= remainder;
            quo_q <= quotient;
            cnt   <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/muldiv_hilo.sv
// muldiv_hilo: multi-cycle multiply/divide unit owning the HI/LO registers.
// Define MULDIV_MADD_EN to make ops 1xx accumulate into {hi,lo}.
module muldiv_hilo
    import muldiv_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MUL_LATENCY = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             divide_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int DW       = 2 * WIDTH;
    localparam int MCW      = (MUL_LATENCY > 2) ? $clog2(MUL_LATENCY - 1) : 1;
    localparam int MUL_LAST = (MUL_LATENCY > 1) ? MUL_LATENCY - 2 : 0;

    state_t state;
    state_t state_nxt;

    logic             mt;
    logic             abort;
    logic             ready;
    logic             issue;
    logic             is_div;
    logic             sgn;
    logic             go_mul;
    logic             go_div;
    logic             dz_go;
    logic             mul_fire;
    logic             div_fire;
    logic             div_last;
    logic             mul_wr;
    logic             mul_acc;
    logic             acc_q;
    logic [MCW-1:0]   mul_cnt;
    logic [DW-1:0]    ext_a;
    logic [DW-1:0]    ext_b;
    logic [DW-1:0]    p_now;
    logic [DW-1:0]    fin_prod;
    logic [DW-1:0]    mul_res;
    logic             neg_a;
    logic             neg_b;
    logic             q_neg;
    logic             r_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] quo_mag;
    logic [WIDTH-1:0] rem_mag;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;
    logic             done_q;
    logic             dz_q;
`ifdef MULDIV_MADD_EN
    logic             sub_q;
    logic             mul_sub;
    logic [DW-1:0]    hilo;
`endif

    // FIX is the divide's done cycle, so it may take a new issue like IDLE.
    assign mt     = mthi | mtlo;
    assign abort  = flush | mt;
    assign ready  = (state == IDLE) || (state == FIX);
    assign issue  = start & ready & ~abort;
    assign is_div = op_is_div(op);
    assign sgn    = op_signed(op);
    assign go_div = issue & is_div;
    assign go_mul = issue & ~is_div;
    assign dz_go  = go_div & (src_b == '0);

    assign ext_a = {{WIDTH{sgn & src_a[WIDTH-1]}}, src_a};
    assign ext_b = {{WIDTH{sgn & src_b[WIDTH-1]}}, src_b};
    assign p_now = ext_a * ext_b;

    generate
        if (MUL_LATENCY == 1) begin : g_mul_comb
            assign fin_prod = p_now;
            assign mul_acc  = op_is_acc(op);
            assign mul_fire = go_mul;
`ifdef MULDIV_MADD_EN
            assign mul_sub  = op_is_sub(op);
`endif
        end else begin : g_mul_pipe
            // HI/LO form the last stage, so MUL_LATENCY-1 product registers.
            logic [DW-1:0] pipe [MUL_LATENCY-1];
            always_ff @(posedge clock) begin
                pipe[0] <= p_now;
                for (int i = 1; i < MUL_LATENCY - 1; i++) begin
                    pipe[i] <= pipe[i-1];
                end
            end
            assign fin_prod = pipe[MUL_LATENCY-2];
            assign mul_acc  = acc_q;
            assign mul_fire = (state == MUL) && (mul_cnt == MCW'(MUL_LAST)) && !abort;
`ifdef MULDIV_MADD_EN
            assign mul_sub  = sub_q;
`endif
        end
    endgenerate

`ifdef MULDIV_MADD_EN
    assign hilo = {hi, lo};
    always_comb begin
        mul_res = fin_prod;
        if (mul_acc) begin
            mul_res = mul_sub ? hilo - fin_prod : hilo + fin_prod;
        end
    end
    assign mul_wr = mul_fire;
`else
    assign mul_res = fin_prod;
    assign mul_wr  = mul_fire & ~mul_acc;
`endif

    assign neg_a = sgn & src_a[WIDTH-1];
    assign neg_b = sgn & src_b[WIDTH-1];
    assign a_mag = WIDTH'(neg_if(MAXW'(src_a), neg_a));
    assign b_mag = WIDTH'(neg_if(MAXW'(src_b), neg_b));

    div_iter #(
        .WIDTH(WIDTH)
    ) u_div (
        .clock     (clock),
        .reset     (reset),
        .load      (go_div),
        .step      (state == DIV),
        .dividend  (a_mag),
        .divisor   (b_mag),
        .quotient  (quo_mag),
        .remainder (rem_mag),
        .last      (div_last)
    );

    // Truncating division: quotient sign from the operand signs, remainder
    // follows the dividend. MIN/-1 lands on MIN without special casing.
    assign div_fire = (state == DIV) && div_last && !abort;
    assign quo_fix  = WIDTH'(neg_if(MAXW'(quo_mag), q_neg));
    assign rem_fix  = WIDTH'(neg_if(MAXW'(rem_mag), r_neg));

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE, FIX: begin
                    state_nxt = IDLE;
                    if (start) begin
                        if (!is_div) begin
                            state_nxt = (MUL_LATENCY == 1) ? IDLE : MUL;
                        end else if (src_b == '0) begin
                            state_nxt = FIX;
                        end else begin
                            state_nxt = DIV;
                        end
                    end
                end
                MUL: begin
                    if (mul_fire) state_nxt = IDLE;
                end
                DIV: begin
                    if (div_fire) state_nxt = FIX;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mul_cnt <= '0;
            acc_q   <= 1'b0;
            q_neg   <= 1'b0;
            r_neg   <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
`ifdef MULDIV_MADD_EN
            sub_q   <= 1'b0;
`endif
        end else begin
            done_q <= mul_fire | div_fire | dz_go;
            dz_q   <= dz_go;
            if (go_mul) begin
                mul_cnt <= '0;
                acc_q   <= op_is_acc(op);
`ifdef MULDIV_MADD_EN
                sub_q   <= op_is_sub(op);
`endif
            end else if (state == MUL) begin
                mul_cnt <= mul_cnt + 1'b1;
            end
            if (go_div) begin
                q_neg <= neg_a ^ neg_b;
                r_neg <= neg_a;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            hi <= '0;
            lo <= '0;
        end else if (!flush) begin
            if (mt) begin
                if (mthi) hi <= src_a;
                if (mtlo) lo <= src_a;
            end else if (mul_wr) begin
                {hi, lo} <= mul_res;
            end else if (div_fire) begin
                hi <= rem_fix;
                lo <= quo_fix;
            end
        end
    end

    assign busy        = (state != IDLE) | done_q;
    assign done        = done_q;
    assign divide_zero = dz_q;

endmodule

// File: tb/tb_muldiv_hilo.sv
// tb_muldiv_hilo: directed vectors for muldiv_hilo at WIDTH=32,
// MUL_LATENCY=2; accumulate expectations follow MULDIV_MADD_EN.
module tb_muldiv_hilo;
    import muldiv_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        mthi;
    logic        mtlo;
    logic        flush;
    logic        busy;
    logic        done;
    logic        divide_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc;
    int cnt;

    always #5 clock = ~clock;

    muldiv_hilo #(
        .WIDTH       (32),
        .MUL_LATENCY (2)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .src_a       (src_a),
        .src_b       (src_b),
        .mthi        (mthi),
        .mtlo        (mtlo),
        .flush       (flush),
        .busy        (busy),
        .done        (done),
        .divide_zero (divide_zero),
        .hi          (hi),
        .lo          (lo)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // Returns in cycle 1 after the issuing edge; operands are then scrambled.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        op    = o;
        src_a = a;
        src_b = b;
        start = 1'b1;
        tick;
        start = 1'b0;
        op    = OP_DIVU;
        src_a = 32'hDEAD_BEEF;
        src_b = 32'h0;
    endtask

    task automatic move(input logic to_hi, input logic [31:0] v);
        mthi  = to_hi;
        mtlo  = !to_hi;
        src_a = v;
        tick;
        mthi  = 1'b0;
        mtlo  = 1'b0;
    endtask

    task automatic wait_done(input int from, input int limit, output int c);
        c = from;
        while (done !== 1'b1 && c < limit) begin
            tick;
            c++;
        end
    endtask

    task automatic count_done(input int n, output int hits);
        hits = 0;
        for (int i = 0; i < n; i++) begin
            tick;
            if (done === 1'b1) hits++;
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        op    = OP_MULT;
        src_a = '0;
        src_b = '0;
        mthi  = 1'b0;
        mtlo  = 1'b0;
        flush = 1'b0;
        tick;
        tick;
        reset = 1'b0;
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dz", divide_zero, 0);

        issue(OP_MULT, 32'hFFFF_FFFF, 32'd2);
        check("mult_c1_busy", busy, 1);
        check("mult_c1_done", done, 0);
        tick;
        check("mult_c2_done", done, 1);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFFE);
        check("mult_c2_busy", busy, 1);
        tick;
        check("mult_c3_done", done, 0);
        check("mult_c3_busy", busy, 0);

        issue(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
        tick;
        check("multu_done", done, 1);
        check("multu_hi", hi, 32'h0000_0001);
        check("multu_lo", lo, 32'hFFFF_FFFE);
        tick;

        issue(OP_MULT, 32'hFFFF_FFFD, 32'd5);
        tick;
        check("mult_neg_hi", hi, 32'hFFFF_FFFF);
        check("mult_neg_lo", lo, 32'hFFFF_FFF1);
        tick;

        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        cnt = 0;
        for (int c = 1; c <= 32; c++) begin
            if (busy === 1'b1 && done === 1'b0) cnt++;
            tick;
        end
        check("div_busy_c1_32", cnt, 32);
        check("div_c33_done", done, 1);
        check("div_c33_busy", busy, 1);
        check("div_lo", lo, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'hFFFF_FFFF);
        check("div_dz", divide_zero, 0);
        tick;
        check("div_c34_busy", busy, 0);

        move(1'b1, 32'h11);
        move(1'b0, 32'h22);
        check("mthi_val", hi, 32'h11);
        check("mtlo_val", lo, 32'h22);

        issue(OP_DIVU, 32'd5, 32'd0);
        check("dz_done", done, 1);
        check("dz_flag", divide_zero, 1);
        check("dz_busy", busy, 1);
        check("dz_hi", hi, 32'h11);
        check("dz_lo", lo, 32'h22);
        tick;
        check("dz_c2_done", done, 0);
        check("dz_c2_flag", divide_zero, 0);
        check("dz_c2_busy", busy, 0);

        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(1, 40, cyc);
        check("minneg_lat", cyc, 33);
        check("minneg_lo", lo, 32'h8000_0000);
        check("minneg_hi", hi, 32'h0);
        check("minneg_dz", divide_zero, 0);
        tick;

        // a stray start in cycle 4 must not disturb the divide
        issue(OP_DIV, 32'd7, 32'hFFFF_FFFE);
        tick;
        tick;
        tick;
        op    = OP_MULT;
        src_a = 32'd3;
        src_b = 32'd3;
        start = 1'b1;
        tick;
        start = 1'b0;
        wait_done(5, 40, cyc);
        check("divneg_lat", cyc, 33);
        check("divneg_lo", lo, 32'hFFFF_FFFD);
        check("divneg_hi", hi, 32'h0000_0001);
        count_done(3, cnt);
        check("divneg_single_done", cnt, 0);

        issue(OP_DIVU, 32'd100, 32'd7);
        cnt = 0;
        for (int c = 1; c <= 10; c++) begin
            if (done === 1'b1) cnt++;
            if (c < 10) tick;
        end
        flush = 1'b1;
        tick;
        flush = 1'b0;
        check("flush_no_done", cnt, 0);
        check("flush_c11_busy", busy, 0);
        check("flush_c11_done", done, 0);
        check("flush_hi", hi, 32'h0000_0001);
        check("flush_lo", lo, 32'hFFFF_FFFD);
        issue(OP_MULTU, 32'd6, 32'd7);
        check("flush_restart_busy", busy, 1);
        tick;
        check("flush_restart_done", done, 1);
        check("flush_restart_hi", hi, 32'h0);
        check("flush_restart_lo", lo, 32'd42);
        count_done(40, cnt);
        check("flush_late_done", cnt, 0);

        issue(OP_MULT, 32'd3, 32'd5);
        tick;
        check("b2b_first_lo", lo, 32'd15);
        op    = OP_MULTU;
        src_a = 32'hFFFF_FFFF;
        src_b = 32'hFFFF_FFFF;
        start = 1'b1;
        tick;
        start = 1'b0;
        check("b2b_c1_busy", busy, 1);
        check("b2b_c1_done", done, 0);
        tick;
        check("b2b_done", done, 1);
        check("b2b_hi", hi, 32'hFFFF_FFFE);
        check("b2b_lo", lo, 32'h0000_0001);
        tick;

        issue(OP_DIVU, 32'd1000, 32'd3);
        tick;
        tick;
        mthi  = 1'b1;
        src_a = 32'hAB;
        tick;
        mthi  = 1'b0;
        check("mt_abort_busy", busy, 0);
        check("mt_abort_hi", hi, 32'hAB);
        check("mt_abort_lo", lo, 32'h0000_0001);
        count_done(40, cnt);
        check("mt_abort_no_done", cnt, 0);

        move(1'b1, 32'h0);
        move(1'b0, 32'd5);
        issue(OP_MADD, 32'd3, 32'd4);
        tick;
        check("madd_done", done, 1);
`ifdef MULDIV_MADD_EN
        check("madd_hi", hi, 32'h0);
        check("madd_lo", lo, 32'd17);
`else
        check("madd_nop_hi", hi, 32'h0);
        check("madd_nop_lo", lo, 32'd5);
`endif
        tick;
        issue(OP_MSUBU, 32'd2, 32'd10);
        tick;
        check("msubu_done", done, 1);
`ifdef MULDIV_MADD_EN
        check("msubu_hi", hi, 32'hFFFF_FFFF);
        check("msubu_lo", lo, 32'hFFFF_FFFD);
`else
        check("msubu_nop_hi", hi, 32'h0);
        check("msubu_nop_lo", lo, 32'd5);
`endif
        tick;

        issue(OP_DIVU, 32'd9, 32'd2);
        tick;
        tick;
        tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        check("rst_mid_hi", hi, 0);
        check("rst_mid_lo", lo, 0);
        check("rst_mid_busy", busy, 0);
        count_done(40, cnt);
        check("rst_mid_no_done", cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
